// File: rtl/en_reg_arbiter.sv
// Round-robin write arbiter in front of a shared enable-loaded register.
// One requester wins per IDLE->WRITE pair; the write strobe pulses for a single cycle.
module en_reg_arbiter #(
    parameter int W = 8,
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   data,
    output logic [N-1:0]     grant,
    output logic             en,
    output logic [W-1:0]     q,
    output logic [IW-1:0]    last_src,
    output logic             busy
);

    // state | meaning
    // IDLE  | search req from ptr, latch winner into win
    // WRITE | strobe en/grant[win] if req[win] still high, else abort
    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    q_q, q_d;
    logic [IW-1:0]   last_src_q, last_src_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW:0]     idx;
    logic            req_win;
    logic [W-1:0]    lane;
    logic            en_c;
    logic [N-1:0]    grant_c;

    // Rotating priority search; idx wraps manually so non-power-of-two N never yields >= N.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(N))
                idx = idx - (IW+1)'(N);
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        req_win = 1'b0;
        lane    = '0;
        for (int i = 0; i < N; i++) begin
            if (win_q == IW'(i)) begin
                req_win = req[i];
                lane    = data[i*W +: W];
            end
        end
    end

    always_comb begin
        en_c    = (state_q == WRITE) && req_win && !reset;
        grant_c = '0;
        for (int i = 0; i < N; i++)
            grant_c[i] = en_c && (win_q == IW'(i));
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        ptr_d      = ptr_q;
        q_d        = q_q;
        last_src_d = last_src_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (req_win) begin
                    q_d        = lane;
                    last_src_d = win_q;
                    ptr_d      = (win_q == IW'(N-1)) ? '0 : win_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= '0;
            ptr_q      <= '0;
            q_q        <= '0;
            last_src_q <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            ptr_q      <= ptr_d;
            q_q        <= q_d;
            last_src_q <= last_src_d;
        end
    end

    assign grant    = grant_c;
    assign en       = en_c;
    assign q        = q_q;
    assign last_src = last_src_q;
    assign busy     = (state_q == WRITE) && !reset;

endmodule

// File: tb/tb_en_reg_arbiter.sv
// Bench for en_reg_arbiter (N=4, W=8): directed stimulus feeds a scoreboard queue,
// an independent monitor pops one entry per en pulse and checks grant, q and last_src.
module tb_en_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        en;
    logic [7:0]  q;
    logic [1:0]  last_src;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] s;
    } exp_t;
    exp_t sb[$];

    en_reg_arbiter #(.W(8), .N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data     (data),
        .grant    (grant),
        .en       (en),
        .q        (q),
        .last_src (last_src),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        data[i*8 +: 8] = v;
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d, input logic [1:0] s);
        exp_t e;
        e.g = g; e.d = d; e.s = s;
        sb.push_back(e);
    endtask

    // Monitor: each en pulse consumes one expected write; q/last_src checked the cycle after.
    initial begin : monitor
        exp_t cur;
        bit   pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("mon_q", {24'd0, q}, {24'd0, cur.d});
                chk("mon_last_src", {30'd0, last_src}, {30'd0, cur.s});
                pend = 1'b0;
            end
            if (en) begin
                if (sb.size() == 0) begin
                    chk("mon_unexpected_en", {31'd0, en}, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("mon_grant", {28'd0, grant}, {28'd0, cur.g});
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    logic [3:0] rr_grant [5];
    logic [7:0] rr_q     [5];

    initial begin : stim
        reset = 1'b1;
        req   = 4'($urandom_range(0, 15));
        data  = $urandom;
        rr_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        // 1. reset values
        cyc();
        req = 4'($urandom_range(0, 15));
        cyc();
        @(negedge clk);
        chk("rst_q", {24'd0, q}, 32'h00);
        chk("rst_last_src", {30'd0, last_src}, 32'd0);
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        cyc();
        reset = 1'b0; req = 4'b0000;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("rel_q", {24'd0, q}, 32'h00);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_en", {31'd0, en}, 32'd0);

        // 2. single request
        cyc();
        req = 4'b0100; set_lane(2, 8'hA5);
        push(4'b0100, 8'hA5, 2'd2);
        @(negedge clk);
        chk("single_c0_busy", {31'd0, busy}, 32'd0);
        cyc();
        @(negedge clk);
        chk("single_c1_grant", {28'd0, grant}, 32'b0100);
        chk("single_c1_en", {31'd0, en}, 32'd1);
        chk("single_c1_busy", {31'd0, busy}, 32'd1);
        cyc();
        req = 4'b0000;
        @(negedge clk);
        chk("single_c2_q", {24'd0, q}, 32'hA5);
        chk("single_c2_last_src", {30'd0, last_src}, 32'd2);
        chk("single_c2_en", {31'd0, en}, 32'd0);

        // 3. round-robin from a fresh pointer
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req = 4'b1111;
        set_lane(0, 8'h10); set_lane(1, 8'h11); set_lane(2, 8'h12); set_lane(3, 8'h13);
        for (int k = 0; k < 5; k++)
            push(rr_grant[k], rr_q[k], 2'(k % 4));
        for (int k = 0; k < 5; k++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("rr_grant_%0d", k), {28'd0, grant}, {28'd0, rr_grant[k]});
            cyc();
            if (k == 4) req = 4'b0000;
            @(negedge clk);
            chk($sformatf("rr_idle_en_%0d", k), {31'd0, en}, 32'd0);
            chk($sformatf("rr_q_%0d", k), {24'd0, q}, {24'd0, rr_q[k]});
        end

        // 4. pointer priority: grant to 1 leaves ptr=2, so 0 beats 1
        cyc();
        req = 4'b0010; set_lane(1, 8'h21);
        push(4'b0010, 8'h21, 2'd1);
        cyc();
        @(negedge clk);
        chk("ptr_first_grant", {28'd0, grant}, 32'b0010);
        cyc();
        req = 4'b0011; set_lane(0, 8'h30); set_lane(1, 8'h31);
        push(4'b0001, 8'h30, 2'd0);
        push(4'b0010, 8'h31, 2'd1);
        cyc();
        @(negedge clk);
        chk("ptr_grant_0", {28'd0, grant}, 32'b0001);
        cyc();
        req = 4'b0010;
        cyc();
        @(negedge clk);
        chk("ptr_grant_1", {28'd0, grant}, 32'b0010);
        cyc();
        req = 4'b0000;
        @(negedge clk);
        chk("ptr_q", {24'd0, q}, 32'h31);

        // 5. abort: requester 3 withdraws during WRITE
        cyc();
        req = 4'b1000; set_lane(3, 8'h77);
        cyc();
        req = 4'b0000;
        @(negedge clk);
        chk("abort_en", {31'd0, en}, 32'd0);
        chk("abort_grant", {28'd0, grant}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        cyc();
        @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_q", {24'd0, q}, 32'h31);
        chk("abort_last_src", {30'd0, last_src}, 32'd1);
        // ptr still 2: search 2,3,0 picks 3 over 0
        cyc();
        req = 4'b1001; set_lane(3, 8'h78);
        push(4'b1000, 8'h78, 2'd3);
        cyc();
        @(negedge clk);
        chk("abort_ptr_grant", {28'd0, grant}, 32'b1000);
        cyc();
        req = 4'b0000;

        // 6. reset in the WRITE cycle
        cyc();
        req = 4'b0010; set_lane(1, 8'h5A);
        push(4'b0010, 8'h5A, 2'd1);
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rstw_en", {31'd0, en}, 32'd0);
        chk("rstw_grant", {28'd0, grant}, 32'd0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("rstw_q", {24'd0, q}, 32'h00);
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_idle_en", {31'd0, en}, 32'd0);
        cyc();
        @(negedge clk);
        chk("rstw_regrant", {28'd0, grant}, 32'b0010);
        cyc();
        req = 4'b0000;
        @(negedge clk);
        chk("rstw_q_after", {24'd0, q}, 32'h5A);

        repeat (3) cyc();
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
